// File: rtl/seq_pkg.sv
// Shared definitions for the two-1s serial pattern transmitter and detector.
// The FSM encoding and the pair-counter width helper live here.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width that holds 0..w/2 non-overlapping pairs.
  function automatic int unsigned pairs_w(input int unsigned w);
    return $clog2(w / 2 + 1);
  endfunction

endpackage

// File: rtl/pair_tracker.sv
// Counts non-overlapping "11" pairs in a serial bit stream, one bit per enabled cycle.
// A pair consumes both of its bits, so 1111 counts two and 111 counts one.
module pair_tracker #(
  parameter int unsigned CW = 3
) (
  input  logic          ck,
  input  logic          r,
  input  logic          clear,
  input  logic          enable,
  input  logic          data_bit,
  output logic [CW-1:0] count,
  output logic          flag
);

  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (enable) begin
      if (data_bit && flag) begin
        count <= count + CW'(1);
        flag  <= 1'b0;
      end else begin
        flag  <= data_bit;
      end
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial word transmitter: shifts a loaded word out MSB-first, framed by a 0-bit DONE cycle,
// and reports how many non-overlapping "11" pairs the word contained.
module serial_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       ck,
  input  logic                       r,
  input  logic                       load,
  input  logic [WIDTH-1:0]           data,
  output logic                       ready,
  output logic                       out,
  output logic                       valid,
  output logic                       done,
  output logic [pairs_w(WIDTH)-1:0]  pairs
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = pairs_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             flag_unused;

  // ready is high exactly in IDLE, so it doubles as the load qualifier.
  assign accept = ready & load;

  // The shift register drains to zero by the end of a word, so its MSB is 0 outside SHIFT.
  assign out = sreg[WIDTH-1];

  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= data;
            cnt   <= '0;
            state <= SHIFT;
            ready <= 1'b0;
            valid <= 1'b1;
          end
        end
        SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          sreg  <= '0;
          ready <= 1'b1;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  pair_tracker #(
    .CW (PW)
  ) u_pair_tracker (
    .ck       (ck),
    .r        (r),
    .clear    (accept),
    .enable   (valid),
    .data_bit (out),
    .count    (pairs),
    .flag     (flag_unused)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed and random checks of serial_pattern_tx against a word-level pair-counting model.
module tb_serial_pattern_tx;
  import seq_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = pairs_w(W);

  logic          ck;
  logic          r;
  logic          load;
  logic [W-1:0]  data;
  logic          ready;
  logic          out;
  logic          valid;
  logic          done;
  logic [PW-1:0] pairs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  serial_pattern_tx #(.WIDTH(W)) dut (
    .ck    (ck),
    .r     (r),
    .load  (load),
    .data  (data),
    .ready (ready),
    .out   (out),
    .valid (valid),
    .done  (done),
    .pairs (pairs)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Scan the word MSB-first; a "11" consumes both bits before the scan resumes.
  function automatic int model_pairs(input logic [W-1:0] d);
    int n = 0;
    int i = W - 1;
    while (i > 0) begin
      if (d[i] && d[i-1]) begin
        n++;
        i -= 2;
      end else begin
        i--;
      end
    end
    return n;
  endfunction

  task automatic start(input logic [W-1:0] d, output int t0);
    int n = 0;
    while (ready !== 1'b1 && n < 2 * W + 8) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(ready), 1);
    load = 1'b1;
    data = d;
    step();
    load = 1'b0;
    t0 = cyc;
  endtask

  // Called in the first-bit cycle; returns in the IDLE cycle after DONE.
  task automatic run_frame(input logic [W-1:0] d, input bit noise, input int exp_pairs);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("bit%0d", i), 32'(out), 32'(d[W-1-i]));
      chk("valid", 32'(valid), 1);
      chk("ready_busy", 32'(ready), 0);
      chk("done_early", 32'(done), 0);
      if (noise) begin
        load = 1'($urandom_range(0, 1));
        data = 8'hAA;
      end
      step();
    end
    chk("done", 32'(done), 1);
    chk("done_out", 32'(out), 0);
    chk("done_valid", 32'(valid), 0);
    chk("done_ready", 32'(ready), 0);
    chk("pairs", 32'(pairs), 32'(exp_pairs));
    if (noise) begin
      load = 1'b1;
      data = 8'hAA;
    end
    step();
    if (noise) load = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input int exp_pairs);
    int t;
    start(d, t);
    run_frame(d, 1'b0, exp_pairs);
    chk("idle_ready", 32'(ready), 1);
    chk("idle_done", 32'(done), 0);
    chk("idle_out", 32'(out), 0);
    step();
    chk("pairs_hold", 32'(pairs), 32'(exp_pairs));
  endtask

  initial begin
    int t0;
    int t1;
    logic [W-1:0] d;

    r    = 1'b1;
    load = 1'b0;
    data = '0;
    step();
    step();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pairs", 32'(pairs), 0);
    r = 1'b0;
    step();

    send(8'b1110_1111, 3);
    send(8'hFF, 4);
    send(8'h00, 0);
    send(8'b0101_0101, 0);
    send(8'b0110_0110, 2);

    // LOAD/DATA activity while busy must not disturb the word in flight.
    start(8'h33, t0);
    run_frame(8'h33, 1'b1, 2);
    chk("noise_idle_ready", 32'(ready), 1);
    chk("noise_pairs", 32'(pairs), 2);

    // LOAD held high: back-to-back words every W+2 cycles.
    load = 1'b1;
    data = 8'hFF;
    step();
    t0   = cyc;
    data = 8'h0F;
    run_frame(8'hFF, 1'b0, 4);
    chk("gap_out", 32'(out), 0);
    chk("gap_ready", 32'(ready), 1);
    chk("gap_pairs", 32'(pairs), 4);
    step();
    t1   = cyc;
    load = 1'b0;
    chk("b2b_spacing", 32'(t1 - t0), 10);
    run_frame(8'h0F, 1'b0, 2);
    step();

    // Reset mid-word after three bits.
    start(8'hFF, t0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pre_rst_bit%0d", i), 32'(out), 1);
      step();
    end
    r = 1'b1;
    #1;
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_pairs", 32'(pairs), 0);
    step();
    r = 1'b0;
    step();
    send(8'hFF, 4);

    for (int n = 0; n < 24; n++) begin
      d = W'($urandom);
      send(d, model_pairs(d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

- Serial bit-stream transmitter for the two-1s sequence detector.
- Accepts a parallel WIDTH-bit word on a load handshake and shifts it out MSB-first on OUT, one bit per CK, framed by at least one 0 between words.
- Counts the non-overlapping "11" pairs it transmits, so a bench or downstream logic can check detector hits per word.
- Sits upstream of the detector's IN port; implemented as a Moore FSM.

## Interface
- WIDTH, default 8: bits per word; even, ≥2.
- CK  in  1  clock; all state changes on rising edge.
- R  in  1  reset, asynchronous, active-high.
- LOAD  in  1  request to send DATA; sampled only when READY=1.
- DATA  in  WIDTH  word to transmit; captured on accepted LOAD.
- READY  out  1  high only in IDLE; block will accept LOAD.
- OUT  out  1  serial data bit; drive to detector IN.
- VALID  out  1  high while OUT carries a data bit (SHIFT state).
- DONE  out  1  one-cycle pulse after the last bit of a word.
- PAIRS  out  $clog2(WIDTH/2+1)  non-overlapping "11" pairs in the last word sent.

## Operation
- States: IDLE, SHIFT, DONE. All outputs are Moore (functions of registers only).
- IDLE:
  - READY=1, OUT=0, VALID=0.
  - On LOAD=1: capture DATA into the shift register, clear the bit counter, clear PAIRS and the pair flag, then go to SHIFT.
- SHIFT:
  - OUT = shift register MSB, VALID=1.
  - Each cycle: shift left, increment the bit counter, update the pair tracker with the bit currently on OUT.
  - After WIDTH bits, go to DONE.
- DONE:
  - OUT=0, VALID=0, DONE=1, READY=0.
  - PAIRS is final. Unconditionally go to IDLE.
- Pair tracker, per transmitted bit:
  - bit=1 and flag=1: PAIRS+1, flag cleared (non-overlapping).
  - Otherwise: flag=bit.
  - This matches detector semantics: 1111 counts 2, 111 counts 1.
- PAIRS holds from DONE until the next accepted LOAD.
- Maximum PAIRS = WIDTH/2; the counter never wraps.
- LOAD while READY=0 is ignored; there is no queueing, and DATA is not re-sampled.
- DATA changes after capture have no effect on the word in flight.
- Reset:
  - Asserting R at any time, including mid-word, immediately forces IDLE, OUT=0, VALID=0, DONE=0, READY=1, PAIRS=0, and clears the shift register, bit counter and flag.
  - The partial word is discarded.

## Timing
- LOAD accepted at edge k: first bit (DATA[WIDTH-1]) on OUT after edge k, stays valid for cycle k+1. Bit i (MSB = 0) is on OUT in cycle k+1+i.
- DONE high in cycle k+WIDTH+1; READY high again in cycle k+WIDTH+2.
- Back-to-back throughput: one word per WIDTH+2 cycles.
- The DONE cycle guarantees at least one 0 on OUT between words, so the detector returns to its idle state between frames.
- LOAD held high continuously: a new word is accepted on every IDLE cycle.
- Bit counter width: $clog2(WIDTH); terminal count WIDTH-1.

## Structure
- Shared package seq_pkg:
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, with 2'd3 decoding to IDLE.
  - A pairs-width function of WIDTH.
  - The detector reuses this package for its own state constants.
- Sub-module pair_tracker, instantiated once:
  - Inputs: CK, R, clear, enable, bit.
  - Outputs: count, flag.
  - Can be reused as a golden model in the detector bench.
- Top level holds the FSM, shift register and bit counter.

## Test plan
- Reset mid-word: LOAD DATA=8'hFF, assert R after 3 bits.
  - Required: OUT=0, VALID=0, READY=1, PAIRS=0 immediately.
  - Required: after R deasserts, the next LOAD sends a full 8 bits.
- Single word DATA=8'b1110_1111, WIDTH=8:
  - Required: OUT sequence 1,1,1,0,1,1,1,1 with VALID=1 for 8 cycles.
  - Required: DONE pulses once, PAIRS=3.
- DATA=8'hFF: PAIRS=4. DATA=8'h00: OUT all 0, PAIRS=0. DATA=8'b0101_0101: PAIRS=0. DATA=8'b0110_0110: PAIRS=2.
- LOAD held high, words 8'hFF then 8'h0F:
  - Required: exactly 10 cycles between the two first bits, with OUT=0 in the DONE and IDLE gap cycles.
  - Required: PAIRS=4, then 2.
- LOAD pulsed during SHIFT and DONE with DATA=8'hAA while sending 8'h33:
  - Required: ignored; 8'h33 is sent intact, PAIRS=2, READY=0 throughout.
- Connect to the two-1s detector and send random words:
  - Required: the number of detector OUT pulses per frame equals PAIRS at DONE.
